// File: rtl/regs_wb_arbiter_pkg.sv
// Shared widths, constants and request payload for the register-file write-back controller.
package regs_wb_arbiter_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned CNT_W    = 4;

    localparam logic [REG_W-1:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regs_wb_arbiter_scoreboard.sv
// Per-register busy scoreboard with decode stall lookup.
// REGS_WB_BYPASS_EN: a register being written this cycle does not stall unless it is re-reserved.
module wb_scoreboard
    import regs_wb_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rsv_valid_i,
    input  logic [REG_W-1:0]    rsv_reg_i,
    input  logic                wr_en_i,
    input  logic [REG_W-1:0]    wr_reg_i,
    input  logic [REG_W-1:0]    rd1_i,
    input  logic [REG_W-1:0]    rd2_i,
    output logic                stall_o,
    output logic [NUM_REGS-1:0] busy_mask_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic [NUM_REGS-1:0] view;

    // Set wins over clear on the same bit; x0 never becomes busy.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (rsv_valid_i && rsv_reg_i != REG_X0) set_vec[rsv_reg_i] = 1'b1;
        if (wr_en_i && wr_reg_i != REG_X0)      clr_vec[wr_reg_i]  = 1'b1;
        busy_d    = (busy_q & ~clr_vec) | set_vec;
        busy_d[0] = 1'b0;
`ifdef REGS_WB_BYPASS_EN
        view = busy_q & ~(clr_vec & ~set_vec);
`else
        view = busy_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign stall_o     = view[rd1_i] | view[rd2_i];
    assign busy_mask_o = busy_q;

endmodule

// File: rtl/regs_wb_arbiter.sv
// Write-back arbiter: shares the register-file write port between execute and load results.
// REGS_WB_BYPASS_EN adds forwarding outputs and lets stall ignore the register being written.
module regs_wb_arbiter
    import regs_wb_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rsv_valid,
    input  logic [REG_W-1:0]    rsv_reg,
    input  logic                ex_valid,
    output logic                ex_ready,
    input  logic [REG_W-1:0]    ex_reg,
    input  logic [DATA_W-1:0]   ex_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [REG_W-1:0]    mem_reg,
    input  logic [DATA_W-1:0]   mem_data,
    input  logic [REG_W-1:0]    readReg1,
    input  logic [REG_W-1:0]    readReg2,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy_mask,
`ifdef REGS_WB_BYPASS_EN
    output logic                fwd_hit1,
    output logic                fwd_hit2,
    output logic [DATA_W-1:0]   fwd_data,
`endif
    output logic                RegWrite,
    output logic [REG_W-1:0]    writeReg,
    output logic [DATA_W-1:0]   writeData_R
);

    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              rw_q, rw_d;
    logic [REG_W-1:0]  wreg_q, wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ex_prio;
    wb_req_t           ex_req, mem_req, win;

    assign ex_req  = '{valid: ex_valid,  addr: ex_reg,  data: ex_data};
    assign mem_req = '{valid: mem_valid, addr: mem_reg, data: mem_data};
    assign ex_prio = (starve_q == CNT_W'(STARVE_MAX));

    // Load results win unless execute has been denied STARVE_MAX cycles in a row.
    always_comb begin
        ex_ready  = ex_req.valid && (!mem_req.valid || ex_prio);
        mem_ready = mem_req.valid && !(ex_req.valid && ex_prio);
        win       = ex_ready ? ex_req : mem_req;
        win.valid = ex_ready || mem_ready;

        starve_d = starve_q;
        if (!ex_req.valid || ex_ready)       starve_d = '0;
        else if (!ex_prio)                   starve_d = starve_q + CNT_W'(1);

        rw_d    = win.valid && (win.addr != REG_X0);
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        if (win.valid) begin
            wreg_d  = win.addr;
            wdata_d = win.data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
            rw_q     <= 1'b0;
            wreg_q   <= '0;
            wdata_q  <= '0;
        end else begin
            starve_q <= starve_d;
            rw_q     <= rw_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
        end
    end

    assign RegWrite    = rw_q;
    assign writeReg    = wreg_q;
    assign writeData_R = wdata_q;

`ifdef REGS_WB_BYPASS_EN
    assign fwd_hit1 = rw_q && (wreg_q == readReg1) && (readReg1 != REG_X0);
    assign fwd_hit2 = rw_q && (wreg_q == readReg2) && (readReg2 != REG_X0);
    assign fwd_data = wdata_q;
`endif

    wb_scoreboard u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .rsv_valid_i (rsv_valid),
        .rsv_reg_i   (rsv_reg),
        .wr_en_i     (rw_q),
        .wr_reg_i    (wreg_q),
        .rd1_i       (readReg1),
        .rd2_i       (readReg2),
        .stall_o     (stall),
        .busy_mask_o (busy_mask)
    );

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Self-checking bench for regs_wb_arbiter with a write-back expectation queue and arbitration model.
module tb_regs_wb_arbiter;

    localparam int SM = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rsv_valid;
    logic [4:0]  rsv_reg;
    logic        ex_valid, ex_ready;
    logic [4:0]  ex_reg;
    logic [63:0] ex_data;
    logic        mem_valid, mem_ready;
    logic [4:0]  mem_reg;
    logic [63:0] mem_data;
    logic [4:0]  readReg1, readReg2;
    logic        stall;
    logic [31:0] busy_mask;
    logic        RegWrite;
    logic [4:0]  writeReg;
    logic [63:0] writeData_R;
`ifdef REGS_WB_BYPASS_EN
    logic        fwd_hit1, fwd_hit2;
    logic [63:0] fwd_data;
`endif

    typedef struct {
        logic        rw;
        logic [4:0]  r;
        logic [63:0] d;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          st = 0;
    logic [4:0]  exp_reg = '0;
    logic [63:0] exp_data = '0;

    regs_wb_arbiter #(.STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n),
        .rsv_valid(rsv_valid), .rsv_reg(rsv_reg),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_reg(ex_reg), .ex_data(ex_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
        .readReg1(readReg1), .readReg2(readReg2),
        .stall(stall), .busy_mask(busy_mask),
`ifdef REGS_WB_BYPASS_EN
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data(fwd_data),
`endif
        .RegWrite(RegWrite), .writeReg(writeReg), .writeData_R(writeData_R)
    );

    always #5 clk = ~clk;

    // One cycle of requests: check handshake now, write stage after the edge.
    task automatic step(input logic exv, input logic [4:0] exr, input logic [63:0] exd,
                        input logic memv, input logic [4:0] memr, input logic [63:0] memd,
                        output logic got_ex);
        exp_t e;
        logic ee, em;
        ex_valid = exv; ex_reg = exr; ex_data = exd;
        mem_valid = memv; mem_reg = memr; mem_data = memd;
        #1;
        ee = exv && (!memv || st == SM);
        em = memv && !(exv && st == SM);
        n_cmp++;
        if (ex_ready !== ee) begin n_err++; $display("FAIL ex_ready: got %b expected %b", ex_ready, ee); end
        n_cmp++;
        if (mem_ready !== em) begin n_err++; $display("FAIL mem_ready: got %b expected %b", mem_ready, em); end
        got_ex = ex_ready;
        if (ee) begin exp_reg = exr; exp_data = exd; end
        else if (em) begin exp_reg = memr; exp_data = memd; end
        e.rw = (ee || em) && (exp_reg != 5'd0);
        e.r  = exp_reg;
        e.d  = exp_data;
        q.push_back(e);
        st = (!exv || ee) ? 0 : ((st < SM) ? st + 1 : st);
        @(posedge clk); #1;
        ex_valid = 1'b0; mem_valid = 1'b0;
        e = q.pop_front();
        n_cmp++;
        if (RegWrite !== e.rw) begin n_err++; $display("FAIL RegWrite: got %b expected %b", RegWrite, e.rw); end
        n_cmp++;
        if (writeReg !== e.r) begin n_err++; $display("FAIL writeReg: got %0d expected %0d", writeReg, e.r); end
        n_cmp++;
        if (writeData_R !== e.d) begin n_err++; $display("FAIL writeData_R: got %h expected %h", writeData_R, e.d); end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        st = 0;
        n_cmp++;
        if (RegWrite !== 1'b0) begin n_err++; $display("FAIL idle_RegWrite: got %b expected 0", RegWrite); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rsv_valid = 1'b0; rsv_reg = '0;
        ex_valid = 1'b1; ex_reg = 5'd3; ex_data = '0;
        mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
        readReg1 = '0; readReg2 = '0;
        #2;
        n_cmp++;
        if (ex_ready !== 1'b1 || mem_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_ready: got ex=%b mem=%b expected ex=1 mem=0", ex_ready, mem_ready);
        end
        n_cmp++;
        if (RegWrite !== 1'b0 || writeReg !== 5'd0 || writeData_R !== 64'd0) begin
            n_err++; $display("FAIL reset_wb: got rw=%b reg=%0d data=%h expected zeros", RegWrite, writeReg, writeData_R);
        end
        n_cmp++;
        if (busy_mask !== 32'd0 || stall !== 1'b0) begin
            n_err++; $display("FAIL reset_busy: got mask=%h stall=%b expected 0", busy_mask, stall);
        end
        ex_valid = 1'b0;
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_ex();
        logic g;
        idle();
        step(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0, g);
    endtask

    task automatic test_contention();
        logic g;
        idle();
        step(1'b1, 5'd3, 64'hA0A0, 1'b1, 5'd4, 64'hB0B0, g);
        n_cmp++;
        if (g !== 1'b0) begin n_err++; $display("FAIL contention_ex_denied: got %b expected 0", g); end
    endtask

    task automatic test_starvation();
        logic       g;
        logic [4:0] pat;
        idle();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 5'(10 + i), 64'(100 + i), 1'b1, 5'(20 + i), 64'(200 + i), g);
            pat[i] = g;
        end
        n_cmp++;
        if (pat !== 5'b01000) begin n_err++; $display("FAIL starve_pattern: got %b expected 01000", pat); end
    endtask

    task automatic test_x0();
        logic g;
        idle();
        step(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'hFF, g);
        n_cmp++;
        if (busy_mask !== 32'd0) begin n_err++; $display("FAIL x0_busy: got %h expected 0", busy_mask); end
    endtask

    task automatic test_scoreboard();
        logic g;
        idle();
        readReg1 = 5'd7; readReg2 = 5'd0;
        rsv_valid = 1'b1; rsv_reg = 5'd7;
        @(posedge clk); #1;
        rsv_valid = 1'b0;
        n_cmp++;
        if (busy_mask !== 32'h80 || stall !== 1'b1) begin
            n_err++; $display("FAIL rsv_x7: got mask=%h stall=%b expected 80/1", busy_mask, stall);
        end
        step(1'b1, 5'd7, 64'hAAAA, 1'b0, 5'd0, 64'd0, g);
`ifdef REGS_WB_BYPASS_EN
        n_cmp++;
        if (stall !== 1'b0 || fwd_hit1 !== 1'b1 || fwd_data !== 64'hAAAA) begin
            n_err++; $display("FAIL bypass_stall: got stall=%b hit=%b data=%h expected 0/1/aaaa", stall, fwd_hit1, fwd_data);
        end
`else
        n_cmp++;
        if (stall !== 1'b1) begin n_err++; $display("FAIL wb_cycle_stall: got %b expected 1", stall); end
`endif
        idle();
        n_cmp++;
        if (busy_mask !== 32'd0 || stall !== 1'b0) begin
            n_err++; $display("FAIL clear_x7: got mask=%h stall=%b expected 0/0", busy_mask, stall);
        end
        rsv_valid = 1'b1; rsv_reg = 5'd7;
        @(posedge clk); #1;
        rsv_valid = 1'b0;
        step(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'hBBBB, g);
        rsv_valid = 1'b1; rsv_reg = 5'd7;
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin n_err++; $display("FAIL rereserve_stall: got %b expected 1", stall); end
        idle();
        rsv_valid = 1'b0;
        n_cmp++;
        if (busy_mask !== 32'h80 || stall !== 1'b1) begin
            n_err++; $display("FAIL set_wins: got mask=%h stall=%b expected 80/1", busy_mask, stall);
        end
    endtask

    task automatic test_reset_mid();
        logic g;
        step(1'b1, 5'd9, 64'hC0DE, 1'b0, 5'd0, 64'd0, g);
        n_cmp++;
        if (busy_mask !== 32'h80) begin n_err++; $display("FAIL pre_reset_busy: got %h expected 80", busy_mask); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (RegWrite !== 1'b0 || writeReg !== 5'd0 || writeData_R !== 64'd0 || busy_mask !== 32'd0 || stall !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got rw=%b reg=%0d data=%h mask=%h stall=%b expected zeros",
                     RegWrite, writeReg, writeData_R, busy_mask, stall);
        end
        st = 0; exp_reg = '0; exp_data = '0; q.delete();
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        step(1'b1, 5'd12, 64'h5555, 1'b0, 5'd0, 64'd0, g);
    endtask

    initial begin
        test_reset();
        test_single_ex();
        test_contention();
        test_starvation();
        test_x0();
        test_scoreboard();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regs_wb_arbiter.md
# regs_wb_arbiter

Write-back controller for the 32×64 integer register file. Shares the register file's single write port between the execute-result and memory-load requesters, and drives the file's RegWrite, writeReg and writeData_R inputs from a registered stage. Keeps a per-register busy scoreboard so decode can stall on pending destinations. Sits between the execute/memory stages and the register file.

## Interface
- STARVE_MAX, default 3: consecutive execute-denied cycles after which execute takes priority; legal range 1..15.

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rsv_valid  in  1  decode issues an instruction with a destination register
- rsv_reg  in  5  destination register to mark busy
- ex_valid  in  1  execute result pending
- ex_ready  out  1  execute result accepted this cycle
- ex_reg  in  5  execute destination register
- ex_data  in  64  execute result
- mem_valid  in  1  load result pending
- mem_ready  out  1  load result accepted this cycle
- mem_reg  in  5  load destination register
- mem_data  in  64  load data
- readReg1, readReg2  in  5 each  decode source registers
- stall  out  1  a source register is busy
- busy_mask  out  32  scoreboard state; bit 0 is always 0
- RegWrite  out  1  register-file write enable, registered
- writeReg  out  5  register-file write address, registered
- writeData_R  out  64  register-file write data, registered

## Operation
- Handshake:
  - A transfer occurs on a cycle with valid && ready.
  - ready is combinational from the valids and the starve counter. It never depends on ready.
  - At most one of ex_ready or mem_ready is high per cycle.
- Arbitration:
  - Default priority is mem over ex.
  - The starve counter increments when ex_valid && !ex_ready, and clears on any ex transfer or when ex_valid is low.
  - When the counter equals STARVE_MAX, ex has priority. The counter saturates at STARVE_MAX.
- A lone valid requester is always granted on the same cycle.
- Write stage:
  - The granted reg and data load into the output register.
  - RegWrite = 1 next cycle if the granted reg ≠ 0.
  - A transfer targeting x0 completes the handshake but produces RegWrite = 0.
  - With no grant, RegWrite = 0 next cycle; writeReg and writeData_R hold their previous values.
- Scoreboard:
  - rsv_valid with rsv_reg ≠ 0 sets busy[rsv_reg] at the clock edge.
  - RegWrite = 1 clears busy[writeReg] at the same edge the register file commits the data.
  - Simultaneous set and clear of the same bit: the set wins.
  - Reserving x0 is ignored.
- stall = busy[readReg1] | busy[readReg2], combinational.

## Timing
- Reset (asynchronous on rst_n low) sets:
  - RegWrite = 0, writeReg = 0, writeData_R = 0
  - busy_mask = 0, starve counter = 0
  - ex_ready and mem_ready follow the valids (a combinational function).
- Reset mid-operation drops all pending writes. The requesters re-present them.
- Latency: a transfer at cycle N gives RegWrite at cycle N+1, register-file commit at the end of N+1, and the busy bit clear visible at N+2.
- Throughput: one write per cycle.
- Back-to-back writes to the same register commit in grant order.

## Configuration
- REGS_WB_BYPASS_EN defined:
  - Adds outputs fwd_hit1, fwd_hit2 (1 bit) and fwd_data (64 bit, equal to writeData_R).
  - fwd_hitK = RegWrite && writeReg == readRegK && readRegK ≠ 0.
  - stall ignores a busy bit whose register is being written this cycle, provided no simultaneous rsv_valid reserves the same register.
- REGS_WB_BYPASS_EN undefined:
  - No forwarding ports.
  - stall stays high until the busy bit clears, one cycle later than with bypass.

## Structure
- Package common holds:
  - REG_X0 constant (5'd0) and NUM_REGS = 32
  - wb_req_t struct {valid, reg[4:0], data[63:0]}
- Sub-module wb_scoreboard holds the busy mask, set/clear logic and stall lookup. The top holds the arbiter, starve counter and write register.

## Test plan
- Single ex transfer: ex_valid, ex_reg = 5, ex_data = 0x1234 at cycle N → ex_ready at N; RegWrite = 1, writeReg = 5, writeData_R = 0x1234 at N+1.
- Contention: ex and mem both valid, no starvation → mem granted; ex_ready = 0.
- Starvation: with STARVE_MAX = 3, both valid continuously → mem wins 3 cycles, ex granted on the 4th, then the counter clears.
- x0 write: mem_reg = 0, data 0xFF → mem_ready = 1, RegWrite stays 0, busy_mask unchanged.
- Scoreboard: reserve x7, readReg1 = 7 → stall = 1. Write to x7 completes → stall drops the cycle after RegWrite (bypass off) or during RegWrite with fwd_hit1 = 1 (bypass on). Reserve and clear of x7 on the same edge → busy[7] stays 1.
- Reset: assert rst_n low while RegWrite = 1 and busy_mask = 0x80 → all outputs 0 immediately, without waiting for a clock edge.
